// File: rtl/cpu_clk_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_clk_ctrl_pkg
// Brief    : Shared FSM state encoding, default timing constants (100 MHz
//            board clock) and a small constant helper for cpu_clk_ctrl.
// Revision : 1.0  initial release
// ============================================================================
package cpu_clk_ctrl_pkg;

  // Clock-generator FSM states
  typedef enum logic [1:0] {
    S_STOP = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_e;

  // 10 ms of stability at 100 MHz before an operator input is believed
  localparam int unsigned DEF_DEB_CYCLES = 32'd1_000_000;

  // Half-periods in board clocks for each Hz-select setting
  localparam int unsigned DEF_DIV0 = 32'd10_000;
  localparam int unsigned DEF_DIV1 = 32'd100_000;
  localparam int unsigned DEF_DIV2 = 32'd1_000_000;
  localparam int unsigned DEF_DIV3 = 32'd10_000_000;

  // Larger of two unsigned values; used to size counters at elaboration
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_clk_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// Module   : cpu_clk_ctrl_debounce
// Brief    : 2-FF synchronizer followed by a stability counter. The debounced
//            output follows the synchronized input only after it has differed
//            for DEB_CYCLES consecutive clocks; any agreeing sample restarts.
// Revision : 1.0  initial release
// ============================================================================
module cpu_clk_ctrl_debounce
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic db_o
);

  // Counter only has to reach DEB_CYCLES-1 before the accept decision
  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW:0] DEB_N = DEB_CYCLES[CW:0];

  logic [1:0]    sync_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;
  logic [CW:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};

  // Synchronize the raw input, then count consecutive disagreeing samples
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= 2'b00;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_inc >= DEB_N) begin
        stable_q <= sync_q[1];
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_inc[CW-1:0];
      end
    end
  end

  assign db_o = stable_q;

endmodule
`default_nettype wire

// File: rtl/cpu_clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_clk_ctrl
// Brief    : Operator front panel clock source for the CPU. Debounces the Go
//            button and run/step switch, divides the board clock in free-run
//            mode and emits exactly one cpu_clk period per Go press in step
//            mode. cpu_ce marks the board cycle in which cpu_clk rises and
//            step_cnt counts those rising edges.
// Revision : 1.0  initial release
// ============================================================================
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned DIV0       = DEF_DIV0,
  parameter int unsigned DIV1       = DEF_DIV1,
  parameter int unsigned DIV2       = DEF_DIV2,
  parameter int unsigned DIV3       = DEF_DIV3,
  parameter int unsigned STEP_HI    = DIV0
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        btn_go,
  input  logic        sw_run,
  input  logic [1:0]  hz,
  output logic        cpu_clk,
  output logic        cpu_ce,
  output logic [31:0] step_cnt
);

  // Phase counter never exceeds the largest half-period minus one
  localparam int unsigned DIV_MAX = max_u(max_u(DIV0, DIV1), max_u(max_u(DIV2, DIV3), STEP_HI));
  localparam int unsigned CNT_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [CNT_W:0] N0     = DIV0[CNT_W:0];
  localparam logic [CNT_W:0] N1     = DIV1[CNT_W:0];
  localparam logic [CNT_W:0] N2     = DIV2[CNT_W:0];
  localparam logic [CNT_W:0] N3     = DIV3[CNT_W:0];
  localparam logic [CNT_W:0] N_STEP = STEP_HI[CNT_W:0];

  logic [1:0]       rst_sync_q;
  logic             rst_n;
  logic [1:0]       hz_s1_q;
  logic [1:0]       hz_q;
  logic             go_db;
  logic             run_db;
  logic             go_prev_q;
  logic             go_press;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W:0]   n_sel;
  logic             div_hit;
  logic             step_hit;
  logic             rise_d;
  logic             cpu_clk_q;
  logic             cpu_ce_q;
  logic [31:0]      step_cnt_q;
  logic [31:0]      step_cnt_d;

  // Reset asserts immediately, releases two clocks after clr_n rises
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // Hz select bank is already clean; only metastability protection needed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hz_s1_q <= 2'b00;
      hz_q    <= 2'b00;
    end else begin
      hz_s1_q <= hz;
      hz_q    <= hz_s1_q;
    end
  end

  cpu_clk_ctrl_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_go_db (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .raw_i  (btn_go),
    .db_o   (go_db)
  );

  cpu_clk_ctrl_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_run_db (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .raw_i  (sw_run),
    .db_o   (run_db)
  );

  // Remember the debounced button so a press becomes a one-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_prev_q <= 1'b0;
    end else begin
      go_prev_q <= go_db;
    end
  end

  assign go_press = go_db & ~go_prev_q;

  // Half-period follows the live Hz select so a change takes effect at once
  always_comb begin
    n_sel = N0;
    unique case (hz_q)
      2'b00:   n_sel = N0;
      2'b01:   n_sel = N1;
      2'b10:   n_sel = N2;
      default: n_sel = N3;
    endcase
  end

  // '>=' rather than '==' so a lowered half-period never forces a wrap
  assign cnt_inc  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign div_hit  = (cnt_inc >= n_sel);
  assign step_hit = (cnt_inc >= N_STEP);

  // Decide whether cpu_clk goes 0->1 on the coming edge
  always_comb begin
    rise_d = 1'b0;
    unique case (state_q)
      S_STOP:  rise_d = !run_db && go_press;
      S_RUN:   rise_d = run_db && !cpu_clk_q && div_hit;
      default: rise_d = 1'b0;
    endcase
  end

  // Clock generator FSM; a high phase is always allowed to finish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_STOP;
      cnt_q     <= '0;
      cpu_clk_q <= 1'b0;
      cpu_ce_q  <= 1'b0;
    end else begin
      cpu_ce_q <= rise_d;
      unique case (state_q)
        S_STOP: begin
          cpu_clk_q <= 1'b0;
          cnt_q     <= '0;
          if (run_db) begin
            state_q <= S_RUN;
          end else if (go_press) begin
            state_q   <= S_STEP;
            cpu_clk_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (!run_db && !cpu_clk_q) begin
            state_q <= S_STOP;
            cnt_q   <= '0;
          end else if (div_hit) begin
            cpu_clk_q <= ~cpu_clk_q;
            cnt_q     <= '0;
            if (!run_db) begin
              state_q <= S_STOP;
            end
          end else begin
            cnt_q <= cnt_inc[CNT_W-1:0];
          end
        end
        S_STEP: begin
          if (step_hit) begin
            cpu_clk_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= S_STOP;
          end else begin
            cnt_q <= cnt_inc[CNT_W-1:0];
          end
        end
        default: begin
          state_q   <= S_STOP;
          cnt_q     <= '0;
          cpu_clk_q <= 1'b0;
        end
      endcase
    end
  end

  // Edge counter advances together with cpu_ce and wraps naturally
  always_comb begin
    step_cnt_d = step_cnt_q + {31'd0, rise_d};
  end

  // Rising-edge counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_q <= 32'd0;
    end else begin
      step_cnt_q <= step_cnt_d;
    end
  end

  assign cpu_clk  = cpu_clk_q;
  assign cpu_ce   = cpu_ce_q;
  assign step_cnt = step_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_clk_ctrl
// Brief    : Scoreboard bench for cpu_clk_ctrl with small timing parameters
//            (DEB_CYCLES=4, DIV0..3=2,3,4,5, STEP_HI=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_clk_ctrl;
  import cpu_clk_ctrl_pkg::*;

  logic        clk    = 1'b0;
  logic        clr_n  = 1'b1;
  logic        btn_go = 1'b0;
  logic        sw_run = 1'b0;
  logic [1:0]  hz     = 2'b00;
  logic        cpu_clk;
  logic        cpu_ce;
  logic [31:0] step_cnt;

  int errors = 0;
  int checks = 0;

  // One expected cpu_clk pulse: step_cnt at the rise, high length, rise-to-rise gap
  typedef struct {
    logic [31:0] cnt;
    int          hi;
    int          gap;
  } exp_t;

  exp_t sb[$];

  cpu_clk_ctrl #(
    .DEB_CYCLES (4),
    .DIV0       (2),
    .DIV1       (3),
    .DIV2       (4),
    .DIV3       (5),
    .STEP_HI    (2)
  ) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .btn_go   (btn_go),
    .sw_run   (sw_run),
    .hz       (hz),
    .cpu_clk  (cpu_clk),
    .cpu_ce   (cpu_ce),
    .step_cnt (step_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] c, input int hi, input int gap);
    exp_t e;
    e.cnt = c;
    e.hi  = hi;
    e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ce(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_ce && n < 200);
    if (!cpu_ce) begin
      checks++;
      errors++;
      $display("FAIL %s: no cpu_ce within 200 cycles, got 0 expected 1", name);
    end
  endtask

  // Scoreboard monitor: every cpu_ce pops one expected pulse
  initial begin : monitor
    int   hi_len;
    int   pend_hi;
    int   gap;
    bit   hi_act;
    exp_t e;
    hi_len  = 0;
    pend_hi = 0;
    gap     = 0;
    hi_act  = 1'b0;
    forever begin
      @(negedge clk);
      if (hi_act && !cpu_clk) begin
        hi_act = 1'b0;
        if (pend_hi != 0) check("high_len", hi_len, pend_hi);
      end else if (hi_act) begin
        hi_len++;
      end
      if (cpu_ce) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ce: got pulse with step_cnt=%0h expected none", step_cnt);
        end else begin
          e = sb.pop_front();
          check("step_cnt_at_ce", step_cnt, e.cnt);
          if (e.gap != 0) check("rise_gap", gap, e.gap);
          pend_hi = e.hi;
        end
        hi_act = 1'b1;
        hi_len = 1;
        gap    = 0;
      end
      gap++;
    end
  end

  // cpu_ce must coincide with each cpu_clk rise and never last two cycles
  initial begin : ce_rules
    logic prev_clk;
    logic prev_ce;
    prev_clk = 1'b0;
    prev_ce  = 1'b0;
    forever begin
      @(negedge clk);
      if (cpu_ce || (cpu_clk && !prev_clk)) begin
        check("ce_on_rise", {31'd0, cpu_ce}, {31'd0, cpu_clk & ~prev_clk});
      end
      if (cpu_ce) check("ce_not_back_to_back", {31'd0, prev_ce}, 32'd0);
      prev_clk = cpu_clk;
      prev_ce  = cpu_ce;
    end
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : stimulus
    // Power-on reset
    #2 clr_n = 1'b0;
    cycles(3);
    check("rst_cpu_clk", {31'd0, cpu_clk}, 32'd0);
    check("rst_cpu_ce", {31'd0, cpu_ce}, 32'd0);
    check("rst_step_cnt", step_cnt, 32'd0);
    clr_n = 1'b1;
    cycles(4);

    // Free-run at hz=00: period 4, high 2
    hz     = 2'b00;
    sw_run = 1'b1;
    push(32'd1, 2, 0);
    push(32'd2, 2, 4);
    push(32'd3, 2, 4);
    push(32'd4, 2, 4);
    push(32'd5, 0, 4);
    for (int i = 0; i < 5; i++) wait_ce("free_run_rise");

    // Reset in the middle of the fifth high phase
    check("pre_reset_high", {31'd0, cpu_clk}, 32'd1);
    #1 clr_n = 1'b0;
    sw_run = 1'b0;
    #1;
    check("midrun_rst_cpu_clk", {31'd0, cpu_clk}, 32'd0);
    check("midrun_rst_cpu_ce", {31'd0, cpu_ce}, 32'd0);
    check("midrun_rst_step_cnt", step_cnt, 32'd0);
    cycles(3);
    clr_n = 1'b1;
    cycles(4);

    // Bouncing Go button yields exactly one step
    push(32'd1, 2, 0);
    btn_go = 1'b1; cycles(1);
    btn_go = 1'b0; cycles(1);
    btn_go = 1'b1; cycles(1);
    btn_go = 1'b0; cycles(1);
    btn_go = 1'b1; cycles(8);
    btn_go = 1'b0; cycles(12);
    check("bounce_one_step", step_cnt, 32'd1);
    btn_go = 1'b1; cycles(3);
    btn_go = 1'b0; cycles(12);
    check("glitch_no_step", step_cnt, 32'd1);
    check("sb_empty_after_step", sb.size(), 32'd0);

    // Stop while high at hz=11: high phase still lasts 5
    hz     = 2'b11;
    sw_run = 1'b1;
    push(32'd2, 5, 0);
    push(32'd3, 5, 10);
    wait_ce("stop_test_rise");
    cycles(6);
    sw_run = 1'b0;
    cycles(30);
    check("stop_cpu_clk_low", {31'd0, cpu_clk}, 32'd0);
    check("stop_state", 32'(dut.state_q), 32'(S_STOP));
    check("stop_step_cnt", step_cnt, 32'd3);

    // Hz drop mid high phase: early toggle, then period 4
    sw_run = 1'b1;
    push(32'd4, 4, 0);
    push(32'd5, 2, 6);
    push(32'd6, 2, 4);
    push(32'd7, 2, 4);
    wait_ce("hz_drop_rise_a");
    cycles(1);
    hz = 2'b00;
    wait_ce("hz_drop_rise_b");
    wait_ce("hz_drop_rise_c");
    sw_run = 1'b0;
    cycles(20);
    check("hz_drop_step_cnt", step_cnt, 32'd7);
    check("hz_drop_state", 32'(dut.state_q), 32'(S_STOP));

    // Edge counter wraps from all-ones to zero
    force dut.step_cnt_q = 32'hFFFF_FFFF;
    cycles(1);
    release dut.step_cnt_q;
    cycles(1);
    check("preload_step_cnt", step_cnt, 32'hFFFF_FFFF);
    push(32'd0, 2, 0);
    btn_go = 1'b1; cycles(8);
    btn_go = 1'b0; cycles(12);
    check("wrap_step_cnt", step_cnt, 32'd0);
    check("sb_empty_end", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
